// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini-CPU: ALU op codes, instruction classes,
// instruction field positions and the controller state encoding.
package mini_cpu_pkg;

    localparam logic [2:0] ALU_ADDU = 3'd0;
    localparam logic [2:0] ALU_SUBU = 3'd1;
    localparam logic [2:0] ALU_ADDS = 3'd2;
    localparam logic [2:0] ALU_SUBS = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;
    localparam logic [2:0] ALU_XOR  = 3'd6;
    localparam logic [2:0] ALU_SLL  = 3'd7;

    localparam logic [1:0] CLS_ALUR = 2'b00;
    localparam logic [1:0] CLS_ALUI = 2'b01;
    localparam logic [1:0] CLS_LI   = 2'b10;
    localparam logic [1:0] CLS_SYS  = 2'b11;

    localparam int CLS_LSB = 14;
    localparam int OP_LSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 7;
    localparam int RS2_LSB = 5;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic usesAlu(input logic [1:0] cls);
        return (cls == CLS_ALUR) || (cls == CLS_ALUI);
    endfunction

endpackage

// File: rtl/regfile.sv
// Small register file: two combinational read ports, one debug read port,
// one synchronous write port and an asynchronous active-low clear.
module regfile #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    input  logic [AW-1:0] i_dbgAddr,
    output logic [7:0]    o_rdata1,
    output logic [7:0]    o_rdata2,
    output logic [7:0]    o_dbgData
);

    logic [7:0] r_mem [2**AW];

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1  = r_mem[i_raddr1];
    assign o_rdata2  = r_mem[i_raddr2];
    assign o_dbgData = r_mem[i_dbgAddr];

endmodule

// File: rtl/exec_ctrl.sv
// Decode/execute/write-back controller: runs each accepted instruction through
// a fixed IDLE -> EXEC -> WB sequence around an external combinational ALU.
module exec_ctrl
    import mini_cpu_pkg::*;
#(
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_clr,
    input  logic [7:0]        alu_result,
    input  logic              alu_cf,
    input  logic              alu_ovf,
    input  logic              alu_z,
    input  logic              alu_neg,
    output logic [3:0]        flags,
    output logic              busy,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    state_t            r_state;
    state_t            w_nextState;
    logic [15:0]       r_instr;
    logic [7:0]        r_holdResult;
    logic [3:0]        r_holdStatus;
    logic [3:0]        r_flags;
    logic              r_illegal;

    logic [1:0]        w_cls;
    logic [2:0]        w_op;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [7:0]        w_imm;
    logic [REG_AW-1:0] w_raddr1;
    logic [7:0]        w_rdata1;
    logic [7:0]        w_rdata2;
    logic [7:0]        w_wdata;
    logic              w_we;
    logic              w_flagsLoad;
    logic              w_setIllegal;
    logic              w_accept;

    assign w_cls  = r_instr[CLS_LSB +: 2];
    assign w_op   = r_instr[OP_LSB +: 3];
    assign w_rd   = r_instr[RD_LSB +: REG_AW];
    assign w_rs1  = r_instr[RS1_LSB +: REG_AW];
    assign w_rs2  = r_instr[RS2_LSB +: REG_AW];
    assign w_imm  = r_instr[IMM_LSB +: 8];

    // ALU-I operates in place on rd, so port 1 switches its address to rd.
    assign w_raddr1 = (w_cls == CLS_ALUI) ? w_rd : w_rs1;
    assign w_wdata  = (w_cls == CLS_LI) ? w_imm : r_holdResult;
    assign w_accept = instr_valid && (r_state == ST_IDLE);

    regfile #(.AW(REG_AW)) u_regfile (
        .clk       (clk),
        .areset_n  (areset_n),
        .i_we      (w_we),
        .i_waddr   (w_rd),
        .i_wdata   (w_wdata),
        .i_raddr1  (w_raddr1),
        .i_raddr2  (w_rs2),
        .i_dbgAddr (dbg_addr),
        .o_rdata1  (w_rdata1),
        .o_rdata2  (w_rdata2),
        .o_dbgData (dbg_data)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        instr_ready  = 1'b0;
        busy         = 1'b0;
        alu_clr      = 1'b1;
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_op       = 3'd0;
        w_we         = 1'b0;
        w_flagsLoad  = 1'b0;
        w_setIllegal = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_nextState = ST_EXEC;
                end
            end
            ST_EXEC: begin
                busy        = 1'b1;
                alu_clr     = 1'b0;
                alu_a       = w_rdata1;
                alu_b       = (w_cls == CLS_ALUI) ? w_imm : w_rdata2;
                alu_op      = w_op;
                w_nextState = ST_WB;
            end
            ST_WB: begin
                busy         = 1'b1;
                w_we         = usesAlu(w_cls) || (w_cls == CLS_LI);
                w_flagsLoad  = usesAlu(w_cls);
                w_setIllegal = (w_cls == CLS_SYS) && (w_op != 3'd0);
                w_nextState  = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Result and status are captured in EXEC so WB is independent of the ALU.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_instr      <= 16'h0000;
            r_holdResult <= 8'h00;
            r_holdStatus <= 4'h0;
            r_flags      <= 4'h0;
            r_illegal    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_instr <= instr;
            end
            if (r_state == ST_EXEC) begin
                r_holdResult <= alu_result;
                r_holdStatus <= {alu_neg, alu_z, alu_ovf, alu_cf};
            end
            if (w_flagsLoad) begin
                r_flags <= r_holdStatus;
            end
            if (w_setIllegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign flags   = r_flags;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed vector table, multi-cycle corner
// sequences, then randomized traffic against an instruction-level model.
module tb_exec_ctrl;

    typedef struct {
        logic [15:0] word;
        logic [1:0]  chkAddr;
        logic [7:0]  expReg;
        logic [3:0]  expFlags;
        logic        expIllegal;
    } vec_t;

    logic        clk = 1'b0;
    logic        areset_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_clr;
    logic [7:0]  alu_result;
    logic        alu_cf;
    logic        alu_ovf;
    logic        alu_z;
    logic        alu_neg;
    logic [3:0]  flags;
    logic        busy;
    logic        illegal;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mRegs [4];
    logic [3:0]  mFlags;
    logic        mIll;
    int          mCount;
    logic [15:0] mInstr;

    always #5 clk = ~clk;

    exec_ctrl #(.REG_AW(2)) dut (
        .clk         (clk),
        .areset_n    (areset_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_clr     (alu_clr),
        .alu_result  (alu_result),
        .alu_cf      (alu_cf),
        .alu_ovf     (alu_ovf),
        .alu_z       (alu_z),
        .alu_neg     (alu_neg),
        .flags       (flags),
        .busy        (busy),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Behavioural 8-bit ALU: returns {neg, z, ovf, cf, result}.
    function automatic logic [11:0] aluRef(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       cf;
        logic       ovf;
        cf  = 1'b0;
        ovf = 1'b0;
        s   = 9'd0;
        case (op)
            3'd0, 3'd2: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[7:0];
                cf = s[8];
                if (op == 3'd2) ovf = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd1, 3'd3: begin
                s  = {1'b0, a} + {1'b0, ~b} + 9'd1;
                r  = s[7:0];
                cf = s[8];
                if (op == 3'd3) ovf = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd4:    r = a & b;
            3'd5:    r = a | b;
            3'd6:    r = a ^ b;
            default: r = a << b[2:0];
        endcase
        return {r[7], (r == 8'h00), ovf, cf, r};
    endfunction

    logic [11:0] aluOut;
    assign aluOut     = alu_clr ? 12'h000 : aluRef(alu_op, alu_a, alu_b);
    assign alu_result = aluOut[7:0];
    assign {alu_neg, alu_z, alu_ovf, alu_cf} = aluOut[11:8];

    function automatic logic [15:0] mkR(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        return {2'b00, op, rd, rs1, rs2, 5'b00000};
    endfunction

    function automatic logic [15:0] mkI(input logic [1:0] cls, input logic [2:0] op, input logic [1:0] rd, input logic [7:0] imm);
        return {cls, op, rd, 1'b0, imm};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic peekReg(input logic [1:0] addr, output logic [7:0] value);
        dbg_addr = addr;
        #1;
        value = dbg_data;
    endtask

    task automatic waitReady();
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!instr_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL readyTimeout: got instr_ready 0, expected 1 within 20 cycles");
        end
    endtask

    task automatic applyReset();
        instr_valid = 1'b0;
        areset_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset_n = 1'b1;
        for (int i = 0; i < 4; i++) mRegs[i] = 8'h00;
        mFlags = 4'h0;
        mIll   = 1'b0;
        mCount = 0;
    endtask

    // Issues one instruction and returns at T+3 (+1), with the result visible.
    task automatic applyStimulus(input logic [15:0] word);
        waitReady();
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = word;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'($urandom());
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    // Instruction-level reference: an instruction's effect lands at the WB edge.
    task automatic modelStep();
        logic [1:0]  cls;
        logic [2:0]  op;
        logic [1:0]  rd;
        logic [11:0] r;
        if (mCount == 0) begin
            if (instr_valid) begin
                mInstr = instr;
                mCount = 2;
            end
        end else if (mCount == 2) begin
            mCount = 1;
        end else begin
            cls = mInstr[15:14];
            op  = mInstr[13:11];
            rd  = mInstr[10:9];
            case (cls)
                2'b00: begin
                    r = aluRef(op, mRegs[mInstr[8:7]], mRegs[mInstr[6:5]]);
                    mRegs[rd] = r[7:0];
                    mFlags    = r[11:8];
                end
                2'b01: begin
                    r = aluRef(op, mRegs[rd], mInstr[7:0]);
                    mRegs[rd] = r[7:0];
                    mFlags    = r[11:8];
                end
                2'b10:   mRegs[rd] = mInstr[7:0];
                default: if (op != 3'd0) mIll = 1'b1;
            endcase
            mCount = 0;
        end
    endtask

    task automatic modelCheck();
        logic [7:0] expA;
        logic [7:0] expB;
        logic [2:0] expOp;
        expA  = 8'h00;
        expB  = 8'h00;
        expOp = 3'd0;
        if (mCount == 2) begin
            expA  = (mInstr[15:14] == 2'b01) ? mRegs[mInstr[10:9]] : mRegs[mInstr[8:7]];
            expB  = (mInstr[15:14] == 2'b01) ? mInstr[7:0] : mRegs[mInstr[6:5]];
            expOp = mInstr[13:11];
        end
        checkOutput("rndReady", 16'(instr_ready), 16'(mCount == 0));
        checkOutput("rndBusy", 16'(busy), 16'(mCount != 0));
        checkOutput("rndAluClr", 16'(alu_clr), 16'(mCount != 2));
        checkOutput("rndAluA", 16'(alu_a), 16'(expA));
        checkOutput("rndAluB", 16'(alu_b), 16'(expB));
        checkOutput("rndAluOp", 16'(alu_op), 16'(expOp));
        checkOutput("rndDbg", 16'(dbg_data), 16'(mRegs[dbg_addr]));
        checkOutput("rndFlags", 16'(flags), 16'(mFlags));
        if (mCount == 0) checkOutput("rndIllegal", 16'(illegal), 16'(mIll));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs [12];
        logic [7:0] v;
        int         acc;

        vecs[0]  = '{mkI(2'b10, 3'd0, 2'd1, 8'h7F), 2'd1, 8'h7F, 4'b0000, 1'b0};
        vecs[1]  = '{mkI(2'b10, 3'd0, 2'd2, 8'h01), 2'd2, 8'h01, 4'b0000, 1'b0};
        vecs[2]  = '{mkR(3'd2, 2'd3, 2'd1, 2'd2),   2'd3, 8'h80, 4'b1010, 1'b0};
        vecs[3]  = '{mkI(2'b10, 3'd0, 2'd1, 8'hFF), 2'd1, 8'hFF, 4'b1010, 1'b0};
        vecs[4]  = '{mkI(2'b01, 3'd0, 2'd1, 8'h01), 2'd1, 8'h00, 4'b0101, 1'b0};
        vecs[5]  = '{mkI(2'b10, 3'd0, 2'd2, 8'h33), 2'd2, 8'h33, 4'b0101, 1'b0};
        vecs[6]  = '{mkI(2'b10, 3'd0, 2'd0, 8'h05), 2'd0, 8'h05, 4'b0101, 1'b0};
        vecs[7]  = '{mkR(3'd1, 2'd0, 2'd0, 2'd0),   2'd0, 8'h00, 4'b0101, 1'b0};
        vecs[8]  = '{16'hC000,                      2'd3, 8'h80, 4'b0101, 1'b0};
        vecs[9]  = '{16'hE000,                      2'd3, 8'h80, 4'b0101, 1'b1};
        vecs[10] = '{mkI(2'b01, 3'd6, 2'd3, 8'hFF), 2'd3, 8'h7F, 4'b0000, 1'b1};
        vecs[11] = '{mkR(3'd4, 2'd2, 2'd2, 2'd3),   2'd2, 8'h33, 4'b0000, 1'b1};

        instr    = 16'h0000;
        dbg_addr = 2'd0;
        applyReset();
        #1;
        checkOutput("rstReady", 16'(instr_ready), 16'd1);
        checkOutput("rstBusy", 16'(busy), 16'd0);
        checkOutput("rstAluClr", 16'(alu_clr), 16'd1);
        checkOutput("rstFlags", 16'(flags), 16'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].word);
            checkOutput("vecReady", 16'(instr_ready), 16'd1);
            peekReg(vecs[i].chkAddr, v);
            checkOutput($sformatf("vec%0dReg", i), 16'(v), 16'(vecs[i].expReg));
            checkOutput($sformatf("vec%0dFlags", i), 16'(flags), 16'(vecs[i].expFlags));
            checkOutput($sformatf("vec%0dIllegal", i), 16'(illegal), 16'(vecs[i].expIllegal));
        end

        // Valid held for six cycles: only words presented while ready are taken.
        waitReady();
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            instr_valid = 1'b1;
            instr       = mkI(2'b10, 3'd0, 2'(k % 4), 8'(8'h10 + k));
            #1;
            if (instr_ready) acc++;
            @(posedge clk);
            #1;
            checkOutput($sformatf("holdBusy%0d", k), 16'(busy), 16'(k % 3 != 2));
        end
        @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("holdAccepted", 16'(acc), 16'd2);
        peekReg(2'd0, v);
        checkOutput("holdR0", 16'(v), 16'h10);
        peekReg(2'd1, v);
        checkOutput("holdR1", 16'(v), 16'h00);
        peekReg(2'd2, v);
        checkOutput("holdR2", 16'(v), 16'h33);
        peekReg(2'd3, v);
        checkOutput("holdR3", 16'(v), 16'h13);

        // Read of rd during WB still shows the old value.
        waitReady();
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = mkI(2'b10, 3'd0, 2'd2, 8'hA5);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        peekReg(2'd2, v);
        checkOutput("wbOldValue", 16'(v), 16'h33);
        @(posedge clk);
        #1;
        peekReg(2'd2, v);
        checkOutput("wbNewValue", 16'(v), 16'hA5);

        // Reset during EXEC drops the instruction and clears everything.
        waitReady();
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = mkI(2'b01, 3'd0, 2'd1, 8'h01);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        checkOutput("midExecBusy", 16'(busy), 16'd1);
        areset_n = 1'b0;
        #1;
        checkOutput("midRstReady", 16'(instr_ready), 16'd1);
        checkOutput("midRstBusy", 16'(busy), 16'd0);
        checkOutput("midRstAluClr", 16'(alu_clr), 16'd1);
        checkOutput("midRstAluA", 16'(alu_a), 16'd0);
        checkOutput("midRstFlags", 16'(flags), 16'd0);
        checkOutput("midRstIllegal", 16'(illegal), 16'd0);
        @(negedge clk);
        areset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            peekReg(2'(i), v);
            checkOutput($sformatf("midRstR%0d", i), 16'(v), 16'h00);
        end

        // Randomized traffic against the instruction-level model.
        applyReset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            instr_valid = 1'($urandom_range(0, 1));
            instr       = ($urandom_range(0, 7) == 0) ? 16'hC000 : 16'($urandom());
            dbg_addr    = 2'($urandom_range(0, 3));
            @(posedge clk);
            modelStep();
            #1;
            modelCheck();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Decode/execute/write-back controller for the mini-CPU datapath, sitting directly upstream of the 8-bit `alu` and consuming its result.

- Accepts 16-bit instructions from fetch over a valid/ready handshake.
- Reads operands from a 4×8-bit register file and drives the ALU operand and op inputs.
- Registers the ALU result and status, then writes the result back and updates a 4-bit flags register.
- Processes one instruction at a time in a fixed 3-cycle sequence.

## Interface
Parameters:
- `REG_AW`, default 2: register address width; the register file holds 2^REG_AW 8-bit registers.

Ports:
- `clk`  in  1  single clock, rising edge
- `areset_n`  in  1  asynchronous active-low reset
- `instr_valid`  in  1  fetch presents an instruction
- `instr`  in  16  instruction word
- `instr_ready`  out  1  controller can accept an instruction
- `alu_a`, `alu_b`  out  8  ALU operands
- `alu_op`  out  3  ALU op: ADDU=0, SUBU=1, ADDS=2, SUBS=3, AND=4, OR=5, XOR=6, SLL=7
- `alu_clr`  out  1  drives the ALU `areset` input; high outside EXEC
- `alu_result`  in  8  ALU result
- `alu_cf`, `alu_ovf`, `alu_z`, `alu_neg`  in  1  ALU status
- `flags`  out  4  {neg, z, ovf, cf}
- `busy`  out  1  high in EXEC and WB
- `illegal`  out  1  sticky; set by a reserved instruction
- `dbg_addr`  in  REG_AW  debug register select
- `dbg_data`  out  8  combinational read of register `dbg_addr`

## Operation
Instruction fields:
- [15:14] class
- [13:11] op
- [10:9] rd
- [8:7] rs1
- [6:5] rs2
- [7:0] imm8 (overlaps the register fields)

Classes:
- 00 ALU-R: rd ← rs1 op rs2. Flags updated.
- 01 ALU-I: rd ← rd op imm8. Flags updated.
- 10 LI: rd ← imm8. Flags unchanged.
- 11 with op=0: NOP. No register or flag change.
- 11 with op≠0: reserved. No register or flag change; sets `illegal`, which stays set until reset.

FSM states:
- IDLE: `instr_ready`=1. On `instr_valid`&&`instr_ready`, latch `instr` and go to EXEC.
- EXEC: `alu_clr`=0. `alu_a`=R[rs1], or R[rd] for ALU-I. `alu_b`=R[rs2], or imm8 for ALU-I. `alu_op`=op. At the clock edge, capture `alu_result` and all four status bits into holding registers. Go to WB.
- WB: for ALU-R and ALU-I, write the held result to rd and load `flags` from the held status. For LI, write imm8 to rd. Go to IDLE.

Operand and write rules:
- Outside EXEC, `alu_a`, `alu_b` and `alu_op` are 0.
- For LI and class 11, EXEC still runs, but the ALU result is discarded.
- r0 is an ordinary writable register.
- rd may equal rs1 and/or rs2: operands are read in EXEC and rd is written at the end of WB, so source values are the pre-instruction values.

## Timing
- Reset (asynchronous, any state): FSM → IDLE; all registers, `flags`, `illegal` and holding registers cleared to 0. Any in-flight instruction is dropped with no write. Output values under reset: `instr_ready`=1, `busy`=0, `alu_clr`=1, ALU outputs 0.
- Handshake: acceptance cycle T (IDLE). EXEC is T+1, WB is T+2. The register write and `flags` update are visible from T+3, when `instr_ready` is high again.
- Throughput: at most one instruction per 3 cycles. `instr_valid` held high during EXEC/WB is ignored, not queued.
- `dbg_data` is combinational. A read of rd during WB returns the old value; the new value appears after the WB edge.
- An instruction change while `instr_ready`=0 has no effect.

## Structure
- Shared package `mini_cpu_pkg` holds:
  - ALU op localparams (shared with `alu`)
  - instruction class codes
  - field bit positions
  - the FSM state encoding (IDLE=0, EXEC=1, WB=2)
- One sub-module, `regfile`: 2^REG_AW × 8, two combinational read ports plus one debug read port, one synchronous write port, async active-low clear.
- `exec_ctrl` contains the FSM, instruction latch, holding registers and flags register.

## Test plan
- Reset, then LI r1,0x7F; LI r2,0x01; ADDS r3=r1,r2 → r3=0x80, flags {neg=1, z=0, ovf=1, cf=0} at cycle T+3 of the ADDS.
- ALU-I ADDU on r1=0xFF with imm 0x01 → r1=0x00, flags {0,1,0,1}. A following LI leaves flags unchanged.
- SUBU r0=r0,r0 with r0=0x05 → r0=0x00, z=1, cf=1. Covers rd=rs1=rs2 aliasing.
- `instr_valid` held high for 6 cycles with different words → exactly 2 instructions accepted, one at each `instr_ready`=1 cycle. `busy` is high for 2 cycles after each acceptance.
- Instruction 0xE000 (class 11, op=4) → `illegal`=1 and stays set; registers and flags unchanged. 0xC000 (NOP) does not set `illegal`.
- `areset_n` asserted during EXEC of ADDU r1 → no write occurs; all registers and flags read 0; `instr_ready`=1 immediately.
